// File: rtl/video_decimator_pack_if.sv
// Packed-word stream from the decimator toward the DDR write arbiter.
// The master side is the decimator; the slave side is the consumer.
interface video_decimator_pack_if #(
    parameter int PIX_PER_WORD = 16,
    parameter int FIFO_DEPTH   = 64
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [16*PIX_PER_WORD-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;
    logic                       burst_ready;
    logic [3:0]                 trans_id;
    logic [LW-1:0]              fifo_level;
    logic                       overflow;

    modport master (
        output out_data, out_valid, out_last,
        output burst_ready, trans_id,
        output fifo_level, overflow,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_last,
        input  burst_ready, trans_id,
        input  fifo_level, overflow,
        output out_ready
    );
endinterface

// File: rtl/video_decimator_pack.sv
// RGB565 decimator: keeps 1 of H_DEC pixels on 1 of V_DEC lines,
// packs kept pixels into words and queues them in a fall-through FIFO.
module video_decimator_pack #(
    parameter int         VIDEO_WIDTH  = 1280,
    parameter int         VIDEO_HEIGHT = 720,
    parameter int         H_DEC        = 4,
    parameter int         V_DEC        = 4,
    parameter int         V_PHASE      = 1,
    parameter int         PIX_PER_WORD = 16,
    parameter int         FIFO_DEPTH   = 64,
    parameter int         BURST_LEN    = 8,
    parameter logic [3:0] IMAGE_TAG    = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs_in,
    input  logic        de_in,
    input  logic [15:0] rgb565_in,
    video_decimator_pack_if.master out_if
);
    localparam int OUT_PIX = (VIDEO_WIDTH / H_DEC)
                           * ((VIDEO_HEIGHT - 1 - V_PHASE) / V_DEC + 1);
    localparam int KW  = $clog2(OUT_PIX + 1);
    localparam int SW  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int LCW = $clog2(VIDEO_HEIGHT + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int WW  = 16 * PIX_PER_WORD;

    localparam logic [3:0]     HD_M1   = 4'(H_DEC - 1);
    localparam logic [3:0]     VD_M1   = 4'(V_DEC - 1);
    localparam logic [3:0]     VPH     = 4'(V_PHASE);
    localparam logic [SW-1:0]  SLOT_M1 = SW'(PIX_PER_WORD - 1);
    localparam logic [KW-1:0]  KMAX    = KW'(OUT_PIX);
    localparam logic [LCW-1:0] LMAX    = LCW'(VIDEO_HEIGHT);
    localparam logic [LW-1:0]  DEPTH   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]  BLEN    = LW'(BURST_LEN);
    localparam logic [LW-1:0]  ONE     = LW'(1);

    logic        vs_s1_q, vs_s2_q, de_s1_q, de_s2_q;
    logic [15:0] rgb_s1_q;
    logic        vs_fall, vs_rise, de_rise, de_fall;

    logic           frame_q;
    logic [LCW-1:0] line_cnt_q;
    logic [3:0]     line_ph_q, pix_ph_q, pix_ph;
    logic           line_kept, kept, is_final, done, premature;

    logic [WW-1:0] shift_q, shift_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [KW-1:0] kept_cnt_q, kept_cnt_d;
    logic          fill_q, fill_d, fill_last_q, fill_last_d;
    logic          mark_q, mark_d;
    logic          wen_q, wlast_q;
    logic [WW-1:0] wword_q;

    logic [WW-1:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] lmem_q;
    logic [AW-1:0]         wr_q, rd_q, tail;
    logic [LW-1:0]         cnt_q, lcnt_q;
    logic                  ovf_q, burst_q;
    logic                  valid, pop, full, acc, wl, tag;

    assign vs_fall = vs_s2_q & ~vs_s1_q;
    assign vs_rise = ~vs_s2_q & vs_s1_q;
    assign de_rise = de_s1_q & ~de_s2_q;
    assign de_fall = ~de_s1_q & de_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_s1_q  <= 1'b0;
            vs_s2_q  <= 1'b0;
            de_s1_q  <= 1'b0;
            de_s2_q  <= 1'b0;
            rgb_s1_q <= '0;
        end else begin
            vs_s1_q  <= vs_in;
            vs_s2_q  <= vs_s1_q;
            de_s1_q  <= de_in;
            de_s2_q  <= de_s1_q;
            rgb_s1_q <= rgb565_in;
        end
    end

    assign pix_ph    = de_rise ? 4'd0 : pix_ph_q;
    assign line_kept = (line_ph_q == VPH) && (line_cnt_q < LMAX);
    assign kept      = frame_q && de_s1_q && !vs_rise && (pix_ph == 4'd0)
                    && line_kept && (kept_cnt_q < KMAX);
    assign is_final  = (kept_cnt_q + 1'b1) == KMAX;
    assign done      = (slot_q == SLOT_M1) || is_final;
    assign premature = vs_rise && frame_q && (kept_cnt_q < KMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q    <= 1'b0;
            line_cnt_q <= '0;
            line_ph_q  <= 4'd0;
            pix_ph_q   <= 4'd0;
        end else begin
            if (vs_fall) begin
                frame_q    <= 1'b1;
                line_cnt_q <= '0;
                line_ph_q  <= 4'd0;
            end else begin
                if (vs_rise)
                    frame_q <= 1'b0;
                if (de_fall) begin
                    if (line_cnt_q != LMAX)
                        line_cnt_q <= line_cnt_q + 1'b1;
                    line_ph_q <= (line_ph_q == VD_M1) ? 4'd0 : line_ph_q + 4'd1;
                end
            end
            if (de_s1_q)
                pix_ph_q <= (pix_ph == HD_M1) ? 4'd0 : pix_ph + 4'd1;
        end
    end

    // A word is cleared the cycle after it completes, so partial words
    // are naturally zero-filled in their upper slots.
    always_comb begin
        shift_d     = fill_q ? '0 : shift_q;
        slot_d      = slot_q;
        kept_cnt_d  = kept_cnt_q;
        fill_d      = 1'b0;
        fill_last_d = 1'b0;
        mark_d      = 1'b0;
        if (kept) begin
            shift_d[slot_q*16 +: 16] = rgb_s1_q;
            slot_d      = done ? '0 : slot_q + 1'b1;
            kept_cnt_d  = kept_cnt_q + 1'b1;
            fill_d      = done;
            fill_last_d = is_final;
        end else if (premature) begin
            fill_d      = (slot_q != '0);
            fill_last_d = (slot_q != '0);
            mark_d      = (slot_q == '0) && (kept_cnt_q != '0);
            slot_d      = '0;
            kept_cnt_d  = '0;
        end else if (vs_fall) begin
            slot_d     = '0;
            kept_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            slot_q      <= '0;
            kept_cnt_q  <= '0;
            fill_q      <= 1'b0;
            fill_last_q <= 1'b0;
            mark_q      <= 1'b0;
            wen_q       <= 1'b0;
            wword_q     <= '0;
            wlast_q     <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            slot_q      <= slot_d;
            kept_cnt_q  <= kept_cnt_d;
            fill_q      <= fill_d;
            fill_last_q <= fill_last_d;
            mark_q      <= mark_d;
            wen_q       <= fill_q;
            wword_q     <= shift_q;
            wlast_q     <= fill_last_q;
        end
    end

    assign valid = (cnt_q != '0);
    assign pop   = valid && out_if.out_ready;
    assign full  = (cnt_q == DEPTH);
    assign acc   = wen_q && (!full || pop);
    assign wl    = wlast_q | mark_q;
    assign tail  = wr_q - 1'b1;
    // Frame ended early on a word boundary: flag the newest stored word.
    assign tag   = mark_q && !wen_q && valid && !(pop && cnt_q == ONE)
                && !lmem_q[tail];

    always_ff @(posedge clk) begin
        if (acc)
            mem_q[wr_q] <= wword_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            lcnt_q  <= '0;
            lmem_q  <= '0;
            ovf_q   <= 1'b0;
            burst_q <= 1'b0;
        end else begin
            if (acc) begin
                lmem_q[wr_q] <= wl;
                wr_q         <= wr_q + 1'b1;
            end
            if (tag)
                lmem_q[tail] <= 1'b1;
            if (pop)
                rd_q <= rd_q + 1'b1;
            cnt_q  <= cnt_q + LW'(acc) - LW'(pop);
            lcnt_q <= lcnt_q + LW'(acc && wl) + LW'(tag)
                    - LW'(pop && lmem_q[rd_q]);
            if (vs_fall)
                ovf_q <= 1'b0;
            if (wen_q && !acc)
                ovf_q <= 1'b1;
            burst_q <= (cnt_q >= BLEN) || (lcnt_q != '0);
        end
    end

    assign out_if.out_valid   = valid;
    assign out_if.out_data    = valid ? mem_q[rd_q] : '0;
    assign out_if.out_last    = valid && lmem_q[rd_q];
    assign out_if.burst_ready = burst_q;
    assign out_if.trans_id    = burst_q ? IMAGE_TAG : 4'd0;
    assign out_if.fifo_level  = cnt_q;
    assign out_if.overflow    = ovf_q;
endmodule

// File: tb/tb_video_decimator_pack.sv
// Directed bench for video_decimator_pack on a 32x8 frame.
// Pixel value = line*32 + column; words are collected by a stream monitor.
module tb_video_decimator_pack;
    logic        clk = 1'b0;
    logic        rst, vs, de;
    logic [15:0] rgb;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [64:0] got_q[$];

    video_decimator_pack_if #(.PIX_PER_WORD(4), .FIFO_DEPTH(8)) vif();

    video_decimator_pack #(
        .VIDEO_WIDTH(32), .VIDEO_HEIGHT(8), .H_DEC(4), .V_DEC(4),
        .V_PHASE(1), .PIX_PER_WORD(4), .FIFO_DEPTH(8), .BURST_LEN(2),
        .IMAGE_TAG(4'd1)
    ) dut (
        .clk(clk), .rst(rst), .vs_in(vs), .de_in(de),
        .rgb565_in(rgb), .out_if(vif)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (vif.out_valid && vif.out_ready)
            got_q.push_back({vif.out_last, vif.out_data});

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [64:0] got,
                         input logic [64:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(int l, int c0, int n);
        logic [63:0] w = '0;
        for (int i = 0; i < n; i++)
            w[16*i +: 16] = 16'(l * 32 + c0 + 4 * i);
        return w;
    endfunction

    function automatic logic [64:0] gw(int k);
        return (k < got_q.size()) ? got_q[k] : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        vs = 1'b1;
        repeat (3) tick();
        vs = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_end();
        vs = 1'b1;
        repeat (6) tick();
    endtask

    task automatic line(input int l, input int n);
        for (int c = 0; c < n; c++) begin
            de  = 1'b1;
            rgb = 16'(l * 32 + c);
            tick();
        end
        de = 1'b0;
        repeat (4) tick();
    endtask

    task automatic full_frame();
        frame_start();
        for (int l = 0; l < 8; l++)
            line(l, 32);
        frame_end();
    endtask

    task automatic drain(input string p);
        repeat (6) tick();
        for (int i = 0; i < 40 && vif.out_valid; i++)
            tick();
        check({p, "_drained"}, 65'(vif.out_valid), 65'(0));
    endtask

    task automatic check_full(input string p, input int nw);
        check({p, "_count"}, 65'(got_q.size()), 65'(nw));
        for (int k = 0; k < nw; k++) begin
            logic [64:0] e;
            e = {(k % 4) == 3, exp_word(((k % 4) < 2) ? 1 : 5, (k % 2) * 16, 4)};
            check($sformatf("%s_w%0d", p, k), gw(k), e);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_valid"}, 65'(vif.out_valid), 65'(0));
        check({p, "_last"},  65'(vif.out_last), 65'(0));
        check({p, "_data"},  65'(vif.out_data), 65'(0));
        check({p, "_burst"}, 65'(vif.burst_ready), 65'(0));
        check({p, "_tid"},   65'(vif.trans_id), 65'(0));
        check({p, "_level"}, 65'(vif.fifo_level), 65'(0));
        check({p, "_ovf"},   65'(vif.overflow), 65'(0));
    endtask

    initial begin
        rst = 1'b1;
        vs  = 1'b0;
        de  = 1'b0;
        rgb = '0;
        vif.out_ready = 1'b0;
        repeat (3) tick();
        check_reset("rst0");
        rst = 1'b0;
        tick();

        // Full frame, consumer always ready
        vif.out_ready = 1'b1;
        got_q.delete();
        full_frame();
        drain("t1");
        check_full("t1", 4);
        check("t1_lit", gw(0), {1'b0, 64'h002C_0028_0024_0020});
        check("t1_ovf", 65'(vif.overflow), 65'(0));

        // Latency of a word completed by column 12 of line 1
        vif.out_ready = 1'b0;
        got_q.delete();
        frame_start();
        line(0, 32);
        for (int c = 0; c <= 12; c++) begin
            de  = 1'b1;
            rgb = 16'(32 + c);
            tick();
        end
        de = 1'b0;
        tick();
        tick();
        check("t2_lat3", 65'(vif.out_valid), 65'(0));
        tick();
        check("t2_lat4", 65'(vif.out_valid), 65'(1));
        repeat (3) tick();
        check("t2_lvl", 65'(vif.fifo_level), 65'(1));
        check("t2_br0", 65'(vif.burst_ready), 65'(0));
        check("t2_tid0", 65'(vif.trans_id), 65'(0));
        frame_end();
        check("t2_last", 65'(vif.out_last), 65'(1));
        check("t2_br_last", 65'(vif.burst_ready), 65'(1));
        check("t2_tid_last", 65'(vif.trans_id), 65'(1));
        vif.out_ready = 1'b1;
        drain("t2");
        check("t2_count", 65'(got_q.size()), 65'(1));
        check("t2_w0", gw(0), {1'b1, exp_word(1, 0, 4)});

        // Burst threshold, then early frame end on a word boundary
        vif.out_ready = 1'b0;
        got_q.delete();
        frame_start();
        line(0, 32);
        for (int c = 0; c <= 28; c++) begin
            de  = 1'b1;
            rgb = 16'(32 + c);
            tick();
        end
        de = 1'b0;
        check("t5_br1", 65'(vif.burst_ready), 65'(0));
        for (int i = 0; i < 12 && vif.fifo_level != 4'd2; i++)
            tick();
        check("t5_lvl2", 65'(vif.fifo_level), 65'(2));
        check("t5_br_same", 65'(vif.burst_ready), 65'(0));
        tick();
        check("t5_br2", 65'(vif.burst_ready), 65'(1));
        check("t5_tid2", 65'(vif.trans_id), 65'(1));
        repeat (4) tick();
        frame_end();
        vif.out_ready = 1'b1;
        drain("t4a");
        check("t4a_count", 65'(got_q.size()), 65'(2));
        check("t4a_w0", gw(0), {1'b0, exp_word(1, 0, 4)});
        check("t4a_w1", gw(1), {1'b1, exp_word(1, 16, 4)});

        // Early frame end with a partial word
        got_q.delete();
        frame_start();
        line(0, 32);
        line(1, 22);
        frame_end();
        drain("t4b");
        check("t4b_count", 65'(got_q.size()), 65'(2));
        check("t4b_w0", gw(0), {1'b0, exp_word(1, 0, 4)});
        check("t4b_w1", gw(1), {1'b1, 64'h0000_0000_0034_0030});

        // Overflow across three stalled frames, then drain
        vif.out_ready = 1'b0;
        got_q.delete();
        repeat (3) full_frame();
        check("t3_lvl", 65'(vif.fifo_level), 65'(8));
        check("t3_ovf", 65'(vif.overflow), 65'(1));
        check("t3_br", 65'(vif.burst_ready), 65'(1));
        frame_start();
        check("t3_ovf_clr", 65'(vif.overflow), 65'(0));
        vif.out_ready = 1'b1;
        for (int l = 0; l < 8; l++)
            line(l, 32);
        frame_end();
        drain("t3");
        check_full("t3", 12);
        check("t3_ovf_end", 65'(vif.overflow), 65'(0));

        // Reset in the middle of line 5
        got_q.delete();
        frame_start();
        for (int l = 0; l < 5; l++)
            line(l, 32);
        for (int c = 0; c < 10; c++) begin
            de  = 1'b1;
            rgb = 16'(5 * 32 + c);
            tick();
        end
        rst = 1'b1;
        tick();
        tick();
        check_reset("rst6");
        de  = 1'b0;
        rst = 1'b0;
        tick();
        got_q.delete();
        full_frame();
        drain("t6");
        check_full("t6", 4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
